store_port_arbiter: RTL and testbench

Round-robin arbiter sharing the single data-cache store port between `NrPorts` committed-store requesters: store buffer drain, cache-maintenance writes, and zero-line writes. It sits between the store-side producers and the dcache request port. Once a transfer is offered downstream it is locked until granted. A `hold_i` input lets the controller quiesce the port before fences and AMOs.

---
 rtl/store_port_arbiter_pkg.sv | 31 +++
 rtl/store_port_rr_pick.sv | 39 +++
 rtl/store_port_arbiter.sv | 133 +++++++++++++
 tb/tb_store_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_port_arbiter_pkg
//  Description : Shared types and helpers for the dcache store-port arbiter:
//                configuration record, FSM state enum, round-robin successor.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_port_arbiter_pkg;

    // Minimal configuration record; only the address and data widths matter here
    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd56, XLEN: 32'd64};

    localparam int unsigned c_MAX_PORTS = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } store_arb_state_e;

    // Next round-robin pointer after granting port idx out of n ports
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_port_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : store_port_rr_pick
//  Description : Combinational rotating-priority picker. Returns the first
//                set request at or above the pointer, wrapping modulo the
//                port count.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_port_rr_pick #(
    parameter int NR_PORTS = 2,
    parameter int IDX_W    = 1
) (
    input  logic [NR_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_rr,
    output logic [IDX_W-1:0]    o_winner,
    output logic                o_valid
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Walk offsets from farthest to nearest so the nearest set request wins last
    always_comb begin
        o_winner   = '0;
        o_valid    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = NR_PORTS - 1; off >= 0; off--) begin
            w_cand     = (int'(i_rr) + off) % NR_PORTS;
            w_cand_idx = w_cand[IDX_W-1:0];
            if (i_req[w_cand_idx]) begin
                o_winner = w_cand_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : store_port_arbiter
//  Description : Round-robin arbiter for the single dcache store port. A
//                transfer offered downstream without a grant is locked until
//                granted; hold_i blocks new arbitration only.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_port_arbiter
    import store_port_arbiter_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty,
    parameter int        NrPorts = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  hold_i,
    input  logic [NrPorts-1:0]                    req_i,
    output logic [NrPorts-1:0]                    gnt_o,
    input  logic [NrPorts*CVA6Cfg.PLEN-1:0]       addr_i,
    input  logic [NrPorts*CVA6Cfg.XLEN-1:0]       data_i,
    input  logic [NrPorts*(CVA6Cfg.XLEN/8)-1:0]   be_i,
    input  logic [NrPorts*2-1:0]                  size_i,
    output logic                                  req_o,
    input  logic                                  gnt_i,
    output logic [CVA6Cfg.PLEN-1:0]               addr_o,
    output logic [CVA6Cfg.XLEN-1:0]               data_o,
    output logic [CVA6Cfg.XLEN/8-1:0]             be_o,
    output logic [1:0]                            size_o,
    output logic                                  idle_o
);

    localparam int c_PLEN  = int'(CVA6Cfg.PLEN);
    localparam int c_XLEN  = int'(CVA6Cfg.XLEN);
    localparam int c_BE    = c_XLEN / 8;
    localparam int c_IDX_W = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    store_arb_state_e   r_state;
    logic [c_IDX_W-1:0] r_rr;
    logic [c_IDX_W-1:0] r_sel;

    logic [c_IDX_W-1:0] w_winner;
    logic               w_valid;
    logic               w_arb_fire;
    logic               w_req;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_next_rr;
    logic [NrPorts-1:0] w_gnt_vec;

    store_port_rr_pick #(
        .NR_PORTS (NrPorts),
        .IDX_W    (c_IDX_W)
    ) u_pick (
        .i_req    (req_i),
        .i_rr     (r_rr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Offer downstream: either the locked port, or a fresh winner when not held
    always_comb begin
        w_arb_fire = (r_state == IDLE) && !hold_i && w_valid;
        w_req      = !rst_i && ((r_state == LOCKED) || w_arb_fire);
        w_idx      = (r_state == LOCKED) ? r_sel : w_winner;
        w_next_rr  = c_IDX_W'(rr_next(int'(w_idx), NrPorts));
        w_gnt_vec  = '0;
        if (w_req && gnt_i) begin
            w_gnt_vec[w_idx] = 1'b1;
        end
    end

    // Payload mux; outputs read zero whenever nothing is offered
    always_comb begin
        addr_o = '0;
        data_o = '0;
        be_o   = '0;
        size_o = '0;
        if (w_req) begin
            addr_o = addr_i[int'(w_idx)*c_PLEN +: c_PLEN];
            data_o = data_i[int'(w_idx)*c_XLEN +: c_XLEN];
            be_o   = be_i[int'(w_idx)*c_BE +: c_BE];
            size_o = size_i[int'(w_idx)*2 +: 2];
        end
    end

    assign req_o  = w_req;
    assign gnt_o  = w_gnt_vec;
    assign idle_o = rst_i || ((r_state == IDLE) && !(|req_i));

    // Arbitration FSM with round-robin pointer and locked-port register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_fire) begin
                        if (gnt_i) begin
                            r_rr <= w_next_rr;
                        end else begin
                            r_sel   <= w_winner;
                            r_state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (gnt_i) begin
                        r_rr    <= w_next_rr;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));

    a_payload_stable: assert property (@(posedge clk_i)
        (!rst_i && r_state == LOCKED && !gnt_i) |=>
        (rst_i || ($stable(addr_o) && $stable(data_o) && $stable(be_o) && $stable(size_o))));

    for (genvar k = 0; k < NrPorts; k++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk_i)
            (!rst_i && req_i[k] && !gnt_o[k]) |=> req_i[k]);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_port_arbiter
//  Description : Self-checking bench for store_port_arbiter (4 ports): directed
//                scenarios with literal expectations, then random traffic
//                compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_port_arbiter;
    import store_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam cva6_cfg_t TB_CFG = '{PLEN: 32'd32, XLEN: 32'd32};

    logic              clk = 1'b0;
    logic              rst_i, hold_i, gnt_i;
    logic [N-1:0]      req_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*DW-1:0]   data_i;
    logic [N*DW/8-1:0] be_i;
    logic [N*2-1:0]    size_i;
    logic [N-1:0]      gnt_o;
    logic              req_o, idle_o;
    logic [AW-1:0]     addr_o;
    logic [DW-1:0]     data_o;
    logic [DW/8-1:0]   be_o;
    logic [1:0]        size_o;

    logic [AW-1:0]   a_addr [N];
    logic [DW-1:0]   a_data [N];
    logic [DW/8-1:0] a_be   [N];
    logic [1:0]      a_size [N];

    int tot = 0;
    int bad = 0;

    // Model state: pending locked offer, its port, and round-robin pointer
    bit           m_locked = 0;
    int           m_sel = 0;
    int           m_rr = 0;
    logic [N-1:0] m_gnt_last = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]       = a_addr[k];
            data_i[k*DW +: DW]       = a_data[k];
            be_i[k*(DW/8) +: DW/8]   = a_be[k];
            size_i[k*2 +: 2]         = a_size[k];
        end
    end

    store_port_arbiter #(.CVA6Cfg(TB_CFG), .NrPorts(N)) dut (
        .clk_i(clk), .rst_i(rst_i), .hold_i(hold_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
        .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .data_o(data_o),
        .be_o(be_o), .size_o(size_o), .idle_o(idle_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: derive expected outputs from the rules, then advance the model
    always @(negedge clk) begin : cmp
        bit           er;
        bit           found;
        int           idx;
        int           p;
        logic [N-1:0] eg;
        bit           eidle;
        er = 0; found = 0; idx = 0; eg = '0;
        if (rst_i) begin
            er = 0;
        end else if (m_locked) begin
            er = 1; idx = m_sel;
        end else if (!hold_i && req_i != '0) begin
            for (int off = 0; off < N; off++) begin
                p = (m_rr + off) % N;
                if (!found && req_i[p]) begin
                    idx = p; found = 1;
                end
            end
            er = 1;
        end
        if (er && gnt_i) eg = N'(1) << idx;
        eidle = rst_i || (!m_locked && req_i == '0);

        chk("cyc req_o", 32'(req_o), 32'(er));
        chk("cyc gnt_o", 32'(gnt_o), 32'(eg));
        chk("cyc idle_o", 32'(idle_o), 32'(eidle));
        if (er) begin
            chk("cyc addr_o", addr_o, a_addr[idx]);
            chk("cyc data_o", data_o, a_data[idx]);
            chk("cyc be_o", 32'(be_o), 32'(a_be[idx]));
            chk("cyc size_o", 32'(size_o), 32'(a_size[idx]));
        end
        if (rst_i) begin
            chk("rst addr_o", addr_o, 32'h0);
            chk("rst data_o", data_o, 32'h0);
        end

        if (rst_i) begin
            m_locked = 0; m_rr = 0; m_sel = 0;
        end else if (er) begin
            if (gnt_i) begin
                m_rr = (idx + 1) % N; m_locked = 0;
            end else begin
                m_locked = 1; m_sel = idx;
            end
        end
        m_gnt_last = eg;
    end

    task automatic cyc(input logic [N-1:0] r, input logic h, input logic g, input logic rs);
        @(posedge clk);
        #1;
        req_i = r; hold_i = h; gnt_i = g; rst_i = rs;
        #2;
    endtask

    initial begin
        rst_i = 1'b1; hold_i = 1'b0; gnt_i = 1'b0; req_i = '0;
        for (int k = 0; k < N; k++) begin
            a_addr[k] = 32'hA000_0000 + 32'(k);
            a_data[k] = 32'hD000_0000 + 32'(k);
            a_be[k]   = 4'(k + 1);
            a_size[k] = 2'(k);
        end

        // Reset values, including with a request and grant present
        cyc(4'b0000, 0, 0, 1);
        chk("reset req_o", 32'(req_o), 0);
        chk("reset idle_o", 32'(idle_o), 1);
        cyc(4'b0001, 0, 1, 1);
        chk("reset gnt_o", 32'(gnt_o), 0);
        chk("reset addr_o", addr_o, 0);

        // Single grant
        cyc(4'b0001, 0, 1, 0);
        chk("single gnt_o", 32'(gnt_o), 32'b0001);
        chk("single addr_o", addr_o, 32'hA000_0000);

        // Alternation
        cyc(4'b0011, 0, 1, 0); chk("alt gnt1", 32'(gnt_o), 32'b0010);
        cyc(4'b0011, 0, 1, 0); chk("alt gnt2", 32'(gnt_o), 32'b0001);
        cyc(4'b0011, 0, 1, 0); chk("alt gnt3", 32'(gnt_o), 32'b0010);
        cyc(4'b0011, 0, 1, 0); chk("alt gnt4", 32'(gnt_o), 32'b0001);

        // Lock under contention
        cyc(4'b0010, 0, 0, 0);
        chk("lock req_o", 32'(req_o), 1);
        chk("lock addr0", addr_o, 32'hA000_0001);
        cyc(4'b0011, 0, 0, 0); chk("lock addr1", addr_o, 32'hA000_0001);
        chk("lock idle_o", 32'(idle_o), 0);
        cyc(4'b0011, 0, 0, 0); chk("lock addr2", addr_o, 32'hA000_0001);
        cyc(4'b0011, 0, 1, 0); chk("lock gnt", 32'(gnt_o), 32'b0010);
        cyc(4'b0001, 0, 1, 0); chk("lock next gnt", 32'(gnt_o), 32'b0001);

        // Hold in IDLE, then hold while locked
        cyc(4'b0011, 1, 1, 0);
        chk("hold req_o", 32'(req_o), 0);
        chk("hold gnt_o", 32'(gnt_o), 0);
        chk("hold idle_o", 32'(idle_o), 0);
        cyc(4'b0011, 1, 1, 0); chk("hold req_o2", 32'(req_o), 0);
        cyc(4'b0011, 0, 0, 0);
        cyc(4'b0011, 1, 0, 0); chk("hold locked req_o", 32'(req_o), 1);
        cyc(4'b0011, 1, 1, 0); chk("hold locked gnt", 32'(gnt_o), 32'b0010);
        cyc(4'b0001, 1, 1, 0); chk("hold after req_o", 32'(req_o), 0);

        // Reset mid-lock on port 1
        cyc(4'b0001, 0, 1, 0); chk("pre-rst gnt", 32'(gnt_o), 32'b0001);
        cyc(4'b0010, 0, 0, 0); chk("pre-rst lock addr", addr_o, 32'hA000_0001);
        cyc(4'b0011, 0, 1, 1);
        chk("midlock rst req_o", 32'(req_o), 0);
        chk("midlock rst gnt_o", 32'(gnt_o), 0);
        cyc(4'b0011, 0, 1, 0); chk("post-rst gnt", 32'(gnt_o), 32'b0001);
        cyc(4'b0010, 0, 1, 0); chk("post-rst gnt2", 32'(gnt_o), 32'b0010);

        // Wrap-around from pointer 3
        cyc(4'b0100, 0, 1, 0); chk("wrap gnt2", 32'(gnt_o), 32'b0100);
        cyc(4'b0001, 0, 1, 0); chk("wrap gnt0", 32'(gnt_o), 32'b0001);
        cyc(4'b1111, 0, 1, 0); chk("wrap rr1", 32'(gnt_o), 32'b0010);
        cyc(4'b1111, 0, 1, 0); chk("wrap rr2", 32'(gnt_o), 32'b0100);
        cyc(4'b1111, 0, 1, 0); chk("wrap rr3", 32'(gnt_o), 32'b1000);
        cyc(4'b1111, 0, 1, 0); chk("wrap rr0", 32'(gnt_o), 32'b0001);

        // Random traffic; requesters keep request and payload until granted
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst_i  = ($urandom_range(0, 149) == 0);
            hold_i = ($urandom_range(0, 3) == 0);
            gnt_i  = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] || m_gnt_last[k]) begin
                    req_i[k]  = ($urandom_range(0, 2) != 0);
                    a_addr[k] = $urandom;
                    a_data[k] = $urandom;
                    a_be[k]   = 4'($urandom_range(0, 15));
                    a_size[k] = 2'($urandom_range(0, 3));
                end
            end
        end

        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
